// File: rtl/io_strobe_edge.sv
// Rising-edge detector for strobes from slower or asynchronous logic.
// Emits a one-clk pulse per rising edge; history resets high so a strobe held across reset is ignored.
module io_strobe_edge #(
  parameter int unsigned SYNC = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic pulse
);

  logic sampled;
  logic prev_q;

  generate
    if (SYNC != 0) begin : g_sync
      logic [1:0] sync_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync_q <= 2'b11;
        end else begin
          sync_q <= {sync_q[0], strobe};
        end
      end
      assign sampled = sync_q[1];
    end else begin : g_nosync
      logic samp_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          samp_q <= 1'b1;
        end else begin
          samp_q <= strobe;
        end
      end
      assign sampled = samp_q;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= sampled;
    end
  end

  assign pulse = sampled & ~prev_q;

endmodule

// File: rtl/io_sfifo.sv
// Single-clock FIFO with full 2^DEPTH capacity, occupancy count, threshold flags,
// sticky overflow/underflow and synchronous flush; strobe or level driven on both sides.
module io_sfifo #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned STROBE_SYNC = 1,
  parameter int unsigned AF_LEVEL    = (1 << DEPTH) - 2,
  parameter int unsigned AE_LEVEL    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  in_strobe,
  input  logic                  in_enable,
  output logic [DATA_WIDTH-1:0] out,
  input  logic                  out_strobe,
  input  logic                  out_enable,
  output logic                  empty,
  output logic                  data_available,
  output logic                  full,
  output logic [DEPTH:0]        count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int unsigned CAPACITY = 1 << DEPTH;
  localparam logic [DEPTH:0] AF_LVL = (DEPTH + 1)'(AF_LEVEL);
  localparam logic [DEPTH:0] AE_LVL = (DEPTH + 1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [CAPACITY];

  logic [DEPTH:0]        wr_ptr_q, wr_ptr_d;
  logic [DEPTH:0]        rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] last_out_q, last_out_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic in_pulse, out_pulse;
  logic wr_req, rd_req, wr_ok, rd_ok;

  io_strobe_edge #(
    .SYNC (STROBE_SYNC)
  ) u_in_edge (
    .clk    (clk),
    .reset  (reset),
    .strobe (in_strobe),
    .pulse  (in_pulse)
  );

  io_strobe_edge #(
    .SYNC (STROBE_SYNC)
  ) u_out_edge (
    .clk    (clk),
    .reset  (reset),
    .strobe (out_strobe),
    .pulse  (out_pulse)
  );

  assign wr_req = in_pulse | in_enable;
  assign rd_req = out_pulse | out_enable;

  assign empty          = (wr_ptr_q == rd_ptr_q);
  assign full           = (wr_ptr_q[DEPTH-1:0] == rd_ptr_q[DEPTH-1:0]) &&
                          (wr_ptr_q[DEPTH] != rd_ptr_q[DEPTH]);
  assign data_available = ~empty;
  assign count          = wr_ptr_q - rd_ptr_q;
  assign almost_full    = (count >= AF_LVL);
  assign almost_empty   = (count <= AE_LVL);
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;
  assign out            = empty ? last_out_q : mem[rd_ptr_q[DEPTH-1:0]];

  // Flush suppresses both transfers and error detection for the cycle.
  assign wr_ok = wr_req & ~full & ~flush;
  assign rd_ok = rd_req & ~empty & ~flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    last_out_d  = last_out_q;
    overflow_d  = overflow_q & ~err_clr;
    underflow_d = underflow_q & ~err_clr;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        last_out_d = mem[rd_ptr_q[DEPTH-1:0]];
      end
      if (wr_req && full)  overflow_d  = 1'b1;
      if (rd_req && empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      last_out_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      last_out_q  <= last_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q[DEPTH-1:0]] <= in;
  end

endmodule

// File: tb/tb_io_sfifo.sv
// Randomised and directed bench for io_sfifo against a queue-based reference model;
// read data is checked by a monitor popping a scoreboard of expected words.
module tb_io_sfifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [7:0] din;
  logic       in_strobe;
  logic       in_enable;
  logic [7:0] dout;
  logic       out_strobe;
  logic       out_enable;
  logic       empty, data_available, full;
  logic [4:0] count;
  logic       almost_full, almost_empty, overflow, underflow;
  logic       err_clr;

  int tests = 0;
  int fails = 0;

  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_last;
  logic       m_ov, m_un;

  io_sfifo dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in             (din),
    .in_strobe      (in_strobe),
    .in_enable      (in_enable),
    .out            (dout),
    .out_strobe     (out_strobe),
    .out_enable     (out_enable),
    .empty          (empty),
    .data_available (data_available),
    .full           (full),
    .count          (count),
    .almost_full    (almost_full),
    .almost_empty   (almost_empty),
    .overflow       (overflow),
    .underflow      (underflow),
    .err_clr        (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: whenever the DUT hands out a word under a level read, compare with scoreboard.
  always @(negedge clk) begin
    if (!reset && out_enable && !flush && !empty) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 32'(dout), 32'hdead);
      end else begin
        check("rd_data", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk();
    int n;
    n = mq.size();
    check("count", 32'(count), 32'(n));
    check("empty", 32'(empty), 32'(n == 0));
    check("data_available", 32'(data_available), 32'(n != 0));
    check("full", 32'(full), 32'(n == 16));
    check("almost_full", 32'(almost_full), 32'(n >= 14));
    check("almost_empty", 32'(almost_empty), 32'(n <= 1));
    check("overflow", 32'(overflow), 32'(m_ov));
    check("underflow", 32'(underflow), 32'(m_un));
    check("out", 32'(dout), (n == 0) ? 32'(m_last) : 32'(mq[0]));
  endtask

  // One clock of level-driven traffic with the model advanced in step.
  task automatic cyc(input logic we, input logic [7:0] d, input logic re,
                     input logic fl, input logic ec);
    bit was_full, was_empty;
    in_enable  = we;
    din        = d;
    out_enable = re;
    flush      = fl;
    err_clr    = ec;
    was_full   = (mq.size() == 16);
    was_empty  = (mq.size() == 0);
    if (fl) begin
      mq.delete();
      m_ov = m_ov && !ec;
      m_un = m_un && !ec;
    end else begin
      if (re && !was_empty) begin
        m_last = mq.pop_front();
        exp_q.push_back(m_last);
      end
      if (we && !was_full) mq.push_back(d);
      m_ov = (we && was_full) || (m_ov && !ec);
      m_un = (re && was_empty) || (m_un && !ec);
    end
    tick();
    in_enable  = 1'b0;
    out_enable = 1'b0;
    flush      = 1'b0;
    err_clr    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; din = '0; in_strobe = 1'b1; in_enable = 1'b0;
    out_strobe = 1'b0; out_enable = 1'b0; err_clr = 1'b0;
    m_last = '0; m_ov = 1'b0; m_un = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (4) tick();
    chk();

    // Single strobe pulse: commits two edges after the sampling edge.
    in_strobe = 1'b0;
    repeat (3) tick();
    din = 8'hA5;
    in_strobe = 1'b1;
    tick();
    in_strobe = 1'b0;
    check("strobe_k", 32'(count), 32'd0);
    tick();
    check("strobe_k1", 32'(count), 32'd0);
    tick();
    mq.push_back(8'hA5);
    check("strobe_k2", 32'(count), 32'd1);
    chk();

    // Long strobe writes once.
    din = 8'h3C;
    in_strobe = 1'b1;
    repeat (5) tick();
    in_strobe = 1'b0;
    repeat (3) tick();
    mq.push_back(8'h3C);
    chk();

    // Read strobe.
    out_strobe = 1'b1;
    tick();
    out_strobe = 1'b0;
    tick();
    check("rstrobe_k1", 32'(count), 32'd2);
    tick();
    m_last = mq.pop_front();
    chk();
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk();

    // Fill to capacity, overflow, drain in order.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      chk();
    end
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    chk();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk();
    end
    check("last_0f", 32'(dout), 32'h0F);

    // Underflow; err_clr loses to a simultaneous error, then clears.
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk();
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk();
    check("un_kept", 32'(underflow), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk();
    check("un_clr", 32'(underflow), 32'd0);

    // Full with read+write: read taken, write dropped.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    chk();
    cyc(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    chk();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'(8'h80 + i), 1'b1, 1'b0, 1'b0);
      check("count8", 32'(count), 32'd8);
    end
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk();

    // Random traffic with occasional flush/err_clr.
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom), 8'($urandom), 1'($urandom),
          ($urandom_range(0, 40) == 0), ($urandom_range(0, 15) == 0));
      chk();
    end

    // Flush with simultaneous write at count 5.
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    chk();
    cyc(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    chk();
    check("flush_out", 32'(dout), 32'h11);
    check("flush_ov", 32'(overflow), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
